// File: rtl/ram_copy_dma.sv
// RAM copy/fill DMA engine sitting between a CPU and a single-port 96x8 RAM.
// In IDLE the CPU owns the RAM pins; during a transfer the engine drives them
// and the CPU sees cpu_stall. Copies take two cycles per byte (read, then
// write), fills take one cycle per byte.
module ram_copy_dma #(
  parameter int DEPTH = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [6:0] src_addr,
  input  logic [6:0] dst_addr,
  input  logic [6:0] length,
  input  logic [7:0] fill_value,
  input  logic       cpu_write,
  input  logic [6:0] cpu_address,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ram_write,
  output logic [6:0] ram_address,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [6:0] i_q;
  logic [6:0] src_q;
  logic [6:0] dst_q;
  logic [6:0] len_q;
  logic [7:0] fill_q;
  logic [7:0] hold_q;
  logic       done_q;
  logic       error_q;
  logic       done_next;
  logic       error_next;

  // Range sums are one bit wider than the address so that an end address of
  // exactly DEPTH is accepted and sums past 127 are never wrapped into range.
  logic [7:0] src_end;
  logic [7:0] dst_end;
  logic       range_bad;
  logic       accept;
  logic       last_byte;
  logic [6:0] src_ptr;
  logic [6:0] dst_ptr;

  assign src_end   = {1'b0, src_addr} + {1'b0, length};
  assign dst_end   = {1'b0, dst_addr} + {1'b0, length};
  assign range_bad = ((mode == 1'b0) && (src_end > DEPTH_W)) || (dst_end > DEPTH_W);
  assign accept    = (state == IDLE) && start && !range_bad && (length != 7'd0);

  // Accepted transfers are range-checked, so these sums never exceed DEPTH-1.
  assign src_ptr   = src_q + i_q;
  assign dst_ptr   = dst_q + i_q;
  assign last_byte = ((i_q + 7'd1) == len_q);

  assign busy      = (state != IDLE);
  assign cpu_stall = busy;
  assign cpu_rdata = ram_rdata;
  assign done      = done_q;
  assign error     = error_q;

  // State register; reset aborts any transfer in progress immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the done/error pulse requests.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_next = 1'b1;
          end else if (length == 7'd0) begin
            done_next = 1'b1;
          end else begin
            state_next = mode ? FILL : RD;
          end
        end
      end
      RD: begin
        state_next = WR;
      end
      WR: begin
        if (last_byte) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = RD;
        end
      end
      FILL: begin
        if (last_byte) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM pin mux: CPU passthrough in IDLE, engine-driven otherwise.
  always_comb begin
    ram_write   = 1'b0;
    ram_address = cpu_address;
    ram_wdata   = cpu_wdata;
    case (state)
      IDLE: begin
        ram_write = cpu_write && ({1'b0, cpu_address} < DEPTH_W);
      end
      RD: begin
        ram_address = src_ptr;
      end
      WR: begin
        ram_address = dst_ptr;
        ram_wdata   = hold_q;
        ram_write   = 1'b1;
      end
      FILL: begin
        ram_address = dst_ptr;
        ram_wdata   = fill_q;
        ram_write   = 1'b1;
      end
      default: begin
        ram_write = 1'b0;
      end
    endcase
  end

  // Transfer datapath: latch parameters on accept, capture read data, step i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q    <= 7'd0;
      src_q  <= 7'd0;
      dst_q  <= 7'd0;
      len_q  <= 7'd0;
      fill_q <= 8'd0;
      hold_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            i_q    <= 7'd0;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= length;
            fill_q <= fill_value;
          end
        end
        RD: begin
          hold_q <= ram_rdata;
        end
        WR: begin
          i_q <= i_q + 7'd1;
        end
        FILL: begin
          i_q <= i_q + 7'd1;
        end
        default: begin
          i_q <= i_q;
        end
      endcase
    end
  end

  // Registered one-cycle status pulses; only one can be requested per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= done_next;
      error_q <= error_next;
    end
  end

endmodule
